// File: rtl/bbox_smpl_iter.sv
// Rasterizer sample iterator: walks every subsample position of a grid-aligned
// bounding box in raster order, one sample per cycle, with the triangle attached.
module bbox_smpl_iter #(
    parameter int unsigned SIGFIG = 24,
    parameter int unsigned RADIX  = 10,
    parameter int unsigned VERTS  = 3,
    parameter int unsigned AXIS   = 3,
    parameter int unsigned COLORS = 3
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic signed [SIGFIG-1:0] tri_R13S   [VERTS][AXIS],
    input  logic        [SIGFIG-1:0] color_R13U [COLORS],
    input  logic signed [SIGFIG-1:0] box_R13S   [2][2],
    input  logic                     validTri_R13H,
    input  logic        [3:0]        subSample_RnnnnU,
    output logic                     halt_RnnnnL,
    output logic signed [SIGFIG-1:0] tri_R14S   [VERTS][AXIS],
    output logic        [SIGFIG-1:0] color_R14U [COLORS],
    output logic signed [SIGFIG-1:0] sample_R14S [2],
    output logic                     validSamp_R14H,
    output logic                     lastSamp_R14H
);

    typedef enum logic {
        WAIT_S = 1'b0,
        TEST_S = 1'b1
    } state_t;

    state_t                     r_state;
    logic signed [SIGFIG-1:0]   r_box [2][2];
    logic        [1:0]          w_ss_lg2;
    logic signed [SIGFIG-1:0]   w_step;
    logic                       w_at_end;
    logic                       w_accept;
    logic                       w_inverted;

    // Subsample mode decode; lowest set bit wins if the mode is not one-hot.
    always_comb begin
        w_ss_lg2 = 2'd0;
        if (subSample_RnnnnU[0])      w_ss_lg2 = 2'd3;
        else if (subSample_RnnnnU[1]) w_ss_lg2 = 2'd2;
        else if (subSample_RnnnnU[2]) w_ss_lg2 = 2'd1;
        else                          w_ss_lg2 = 2'd0;
    end

    assign w_step     = SIGFIG'(1) << (RADIX - 32'(w_ss_lg2));
    assign w_at_end   = (r_state == TEST_S) &&
                        (sample_R14S[0] == r_box[1][0]) &&
                        (sample_R14S[1] == r_box[1][1]);
    assign halt_RnnnnL   = (r_state == WAIT_S) || w_at_end;
    assign w_accept      = validTri_R13H && halt_RnnnnL;
    assign w_inverted    = (box_R13S[1][0] < box_R13S[0][0]) ||
                           (box_R13S[1][1] < box_R13S[0][1]);
    assign lastSamp_R14H = validSamp_R14H && w_at_end;

    // Accept has priority over advancing, so a new box loads on the last sample.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state        <= WAIT_S;
            r_box          <= '{default: '0};
            tri_R14S       <= '{default: '0};
            color_R14U     <= '{default: '0};
            sample_R14S    <= '{default: '0};
            validSamp_R14H <= 1'b0;
        end else if (w_accept && !w_inverted) begin
            r_state        <= TEST_S;
            r_box          <= box_R13S;
            tri_R14S       <= tri_R13S;
            color_R14U     <= color_R13U;
            sample_R14S[0] <= box_R13S[0][0];
            sample_R14S[1] <= box_R13S[0][1];
            validSamp_R14H <= 1'b1;
        end else if (w_accept) begin
            // Inverted box: dropped, and any walk finishing this cycle still ends.
            r_state        <= WAIT_S;
            validSamp_R14H <= 1'b0;
        end else if (r_state == TEST_S) begin
            if (sample_R14S[0] < r_box[1][0]) begin
                sample_R14S[0] <= sample_R14S[0] + w_step;
            end else if (sample_R14S[1] < r_box[1][1]) begin
                sample_R14S[0] <= r_box[0][0];
                sample_R14S[1] <= sample_R14S[1] + w_step;
            end else begin
                r_state        <= WAIT_S;
                validSamp_R14H <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_bbox_smpl_iter.sv
// Directed bench for bbox_smpl_iter: walk order, subsample steps, back-to-back,
// stall hold, degenerate/inverted boxes and mid-walk reset.
module tb_bbox_smpl_iter;

    localparam int unsigned SIGFIG = 24;
    localparam int unsigned VERTS  = 3;
    localparam int unsigned AXIS   = 3;
    localparam int unsigned COLORS = 3;

    logic                     clk;
    logic                     rst;
    logic signed [SIGFIG-1:0] tri_R13S   [VERTS][AXIS];
    logic        [SIGFIG-1:0] color_R13U [COLORS];
    logic signed [SIGFIG-1:0] box_R13S   [2][2];
    logic                     validTri_R13H;
    logic        [3:0]        subSample_RnnnnU;
    logic                     halt_RnnnnL;
    logic signed [SIGFIG-1:0] tri_R14S   [VERTS][AXIS];
    logic        [SIGFIG-1:0] color_R14U [COLORS];
    logic signed [SIGFIG-1:0] sample_R14S [2];
    logic                     validSamp_R14H;
    logic                     lastSamp_R14H;

    int n_vec = 0;
    int n_err = 0;

    bbox_smpl_iter dut (
        .clk              (clk),
        .rst              (rst),
        .tri_R13S         (tri_R13S),
        .color_R13U       (color_R13U),
        .box_R13S         (box_R13S),
        .validTri_R13H    (validTri_R13H),
        .subSample_RnnnnU (subSample_RnnnnU),
        .halt_RnnnnL      (halt_RnnnnL),
        .tri_R14S         (tri_R14S),
        .color_R14U       (color_R14U),
        .sample_R14S      (sample_R14S),
        .validSamp_R14H   (validSamp_R14H),
        .lastSamp_R14H    (lastSamp_R14H)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input longint obs, input longint exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled at the falling edge.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic set_tri(input int base);
        for (int v = 0; v < int'(VERTS); v++)
            for (int a = 0; a < int'(AXIS); a++)
                tri_R13S[v][a] = SIGFIG'(base + 3 * v + a);
        for (int c = 0; c < int'(COLORS); c++)
            color_R13U[c] = SIGFIG'(base + 50 + c);
    endtask

    task automatic set_box(input int llx, input int lly, input int urx, input int ury);
        box_R13S[0][0] = SIGFIG'(llx);
        box_R13S[0][1] = SIGFIG'(lly);
        box_R13S[1][0] = SIGFIG'(urx);
        box_R13S[1][1] = SIGFIG'(ury);
    endtask

    task automatic chk_samp(input string tag, input int x, input int y,
                            input logic last, input logic halt, input int tbase);
        chk({tag, ".valid"}, longint'(validSamp_R14H), 1);
        chk({tag, ".x"},     longint'(sample_R14S[0]), longint'(x));
        chk({tag, ".y"},     longint'(sample_R14S[1]), longint'(y));
        chk({tag, ".last"},  longint'(lastSamp_R14H), longint'(last));
        chk({tag, ".halt"},  longint'(halt_RnnnnL), longint'(halt));
        chk({tag, ".tri"},   longint'(tri_R14S[2][2]), longint'(tbase + 8));
        chk({tag, ".color"}, longint'(color_R14U[1]), longint'(tbase + 51));
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, ".valid"}, longint'(validSamp_R14H), 0);
        chk({tag, ".last"},  longint'(lastSamp_R14H), 0);
        chk({tag, ".halt"},  longint'(halt_RnnnnL), 1);
    endtask

    initial begin
        int ex[6];
        int ey[6];
        ex = '{0, 1024, 2048, 0, 1024, 2048};
        ey = '{0, 0, 0, 1024, 1024, 1024};

        rst = 1'b0;
        validTri_R13H = 1'b0;
        subSample_RnnnnU = 4'b1000;
        set_tri(0);
        set_box(0, 0, 0, 0);
        tick();
        tick();

        // Reset state
        chk_idle("reset");
        chk("reset.x", longint'(sample_R14S[0]), 0);
        chk("reset.y", longint'(sample_R14S[1]), 0);
        chk("reset.tri", longint'(tri_R14S[0][0]), 0);
        chk("reset.color", longint'(color_R14U[0]), 0);
        rst = 1'b1;
        tick();
        chk_idle("post_reset");

        // Basic walk, step 1024
        set_tri(100);
        set_box(0, 0, 2048, 1024);
        validTri_R13H = 1'b1;
        tick();
        validTri_R13H = 1'b0;
        for (int i = 0; i < 6; i++) begin
            chk_samp($sformatf("basic%0d", i), ex[i], ey[i], i == 5, i == 5, 100);
            tick();
        end
        chk_idle("basic_done");

        // Subsample step 128
        subSample_RnnnnU = 4'b0001;
        set_tri(120);
        set_box(512, 512, 896, 512);
        validTri_R13H = 1'b1;
        tick();
        validTri_R13H = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk_samp($sformatf("sub%0d", i), 512 + 128 * i, 512, i == 3, i == 3, 120);
            tick();
        end
        chk_idle("sub_done");

        // Back-to-back with stall hold: a stale box is shown while busy, then replaced
        subSample_RnnnnU = 4'b1000;
        set_tri(200);
        set_box(0, 0, 2048, 0);
        validTri_R13H = 1'b1;
        tick();
        set_tri(900);
        set_box(8192, 8192, 8192, 8192);
        chk_samp("b2b_s0", 0, 0, 1'b0, 1'b0, 200);
        tick();
        chk_samp("b2b_s1", 1024, 0, 1'b0, 1'b0, 200);
        set_tri(300);
        set_box(4096, 4096, 4096, 5120);
        tick();
        chk_samp("b2b_s2", 2048, 0, 1'b1, 1'b1, 200);
        tick();
        validTri_R13H = 1'b0;
        chk_samp("b2b_t2s0", 4096, 4096, 1'b0, 1'b0, 300);
        tick();
        chk_samp("b2b_t2s1", 4096, 5120, 1'b1, 1'b1, 300);
        tick();
        chk_idle("b2b_done");

        // Degenerate single-sample box
        set_tri(400);
        set_box(3072, 2048, 3072, 2048);
        validTri_R13H = 1'b1;
        tick();
        validTri_R13H = 1'b0;
        chk_samp("degen", 3072, 2048, 1'b1, 1'b1, 400);
        tick();
        chk_idle("degen_done");

        // Inverted box is dropped
        set_tri(500);
        set_box(2048, 0, 1024, 0);
        validTri_R13H = 1'b1;
        tick();
        validTri_R13H = 1'b0;
        chk_idle("inv0");
        chk("inv0.tri_kept", longint'(tri_R14S[2][2]), 408);
        tick();
        chk_idle("inv1");

        // Reset on the 3rd sample of a 4x4 box
        set_tri(600);
        set_box(0, 0, 3072, 3072);
        validTri_R13H = 1'b1;
        tick();
        validTri_R13H = 1'b0;
        tick();
        tick();
        chk_samp("rst_mid", 2048, 0, 1'b0, 1'b0, 600);
        rst = 1'b0;
        tick();
        rst = 1'b1;
        chk_idle("rst_after");
        chk("rst_after.x", longint'(sample_R14S[0]), 0);
        chk("rst_after.tri", longint'(tri_R14S[2][2]), 0);
        chk("rst_after.color", longint'(color_R14U[1]), 0);
        tick();
        chk_idle("rst_after2");

        // New triangle accepted normally after reset
        set_tri(700);
        set_box(1024, 1024, 1024, 1024);
        validTri_R13H = 1'b1;
        tick();
        validTri_R13H = 1'b0;
        chk_samp("post_rst", 1024, 1024, 1'b1, 1'b1, 700);
        tick();
        chk_idle("post_rst_done");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
